// File: rtl/comb_controller.sv
// comb_controller
// -----------------------------------------------------------------------------
// Sequencing FSM for the combination datapath. It computes C(N,M) without
// recursion hardware by walking the recurrence C(n,m) = C(n-1,m) + C(n-1,m-1)
// (C(n,0) = C(n,n) = 1) and keeping pending work as 23-bit frames
// {flag, n, m, value} on the datapath stack. The result is left in comb1
// (datapath out_) when done pulses.
//
// Frame flags: 0 = unexpanded A child or root, 2 = unexpanded B child,
// 1/3 = expanded parent whose own role is A-or-root / B. A resolved A value is
// parked on the stack with flag 0 until its B sibling resolves.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a computation (sampled in IDLE only)
//   N, M              operands (same values as the datapath N/M inputs)
//   Lend, end_        datapath status: base case / root frame reached
//   Flag_Out          flag field of the current stack top
//   Sn, Sm            n/m input mux: 0=reg, 1=reg-1, 2=N/M
//   Sc                value mux: 0=comb1+comb2, 1=constant 1
//   Flag_In           flag of the pushed frame
//   weN..we2          datapath register enables
//   push, pop, top    stack commands
//   busy, done, err   run in progress, completion pulse, sticky error
//   cycles            (only with CNTRL_CYCLE_COUNT_EN) saturating busy-cycle count
//
// Optional feature macro: CNTRL_CYCLE_COUNT_EN
// All outputs are registered: they are decoded from the next state so that
// they line up with the state register in the following cycle.
// -----------------------------------------------------------------------------
module comb_controller #(
    parameter int STACK_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] N,
    input  logic [3:0] M,
    input  logic       Lend,
    input  logic       end_,
    input  logic [1:0] Flag_Out,
    output logic [1:0] Sn,
    output logic [1:0] Sm,
    output logic       Sc,
    output logic [1:0] Flag_In,
    output logic       weN,
    output logic       weM,
    output logic       wen,
    output logic       wem,
    output logic       we1,
    output logic       we2,
    output logic       push,
    output logic       pop,
    output logic       top,
    output logic       busy,
    output logic       done,
`ifdef CNTRL_CYCLE_COUNT_EN
    output logic [15:0] cycles,
`endif
    output logic       err
);

    localparam logic [4:0] S_IDLE      = 5'd0;
    localparam logic [4:0] S_LOAD      = 5'd1;
    localparam logic [4:0] S_PUSH_ROOT = 5'd2;
    localparam logic [4:0] S_FETCH     = 5'd3;
    localparam logic [4:0] S_EVAL      = 5'd4;
    localparam logic [4:0] S_EXP_POP   = 5'd5;
    localparam logic [4:0] S_EXP_PAR   = 5'd6;
    localparam logic [4:0] S_EXP_CHILD = 5'd7;
    localparam logic [4:0] S_BASE_POP  = 5'd8;
    localparam logic [4:0] S_RES       = 5'd9;
    localparam logic [4:0] S_A_VAL     = 5'd10;
    localparam logic [4:0] S_A_CHILDB  = 5'd11;
    localparam logic [4:0] S_B_TMP     = 5'd12;
    localparam logic [4:0] S_B_POPT    = 5'd13;
    localparam logic [4:0] S_B_POPA    = 5'd14;
    localparam logic [4:0] S_B_POPP    = 5'd15;
    localparam logic [4:0] S_FIN_PUSH  = 5'd16;
    localparam logic [4:0] S_FIN_POP   = 5'd17;
    localparam logic [4:0] S_DONE      = 5'd18;

    localparam int              DW         = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0]   DEPTH_MAX  = DW'(STACK_DEPTH);
    localparam logic [DW-1:0]   DEPTH_ONE  = DW'(1);
    localparam logic [DW-1:0]   DEPTH_ZERO = DW'(0);

    typedef struct packed {
        logic [1:0] sn;
        logic [1:0] sm;
        logic       sc;
        logic [1:0] flag_in;
        logic       we_nn;
        logic       we_mm;
        logic       we_n;
        logic       we_m;
        logic       we_1;
        logic       we_2;
        logic       push;
        logic       pop;
        logic       top;
        logic       busy;
        logic       done;
    } ctl_t;

    logic [4:0]    state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          role_q, role_d;
    logic          vsel_q, vsel_d;
    logic          err_q, err_d;
    ctl_t          ctl_q;
    logic          fault_s;
    logic          blocked_d_s;
    logic          flag_unused_s;

    // Only the role bit of the top flag steers the controller.
    assign flag_unused_s = Flag_Out[0];

    function automatic logic is_push_st(input logic [4:0] st);
        case (st)
            S_PUSH_ROOT, S_EXP_PAR, S_EXP_CHILD, S_A_VAL,
            S_A_CHILDB, S_B_TMP, S_FIN_PUSH: is_push_st = 1'b1;
            default:                          is_push_st = 1'b0;
        endcase
    endfunction

    function automatic logic is_pop_st(input logic [4:0] st);
        case (st)
            S_EXP_POP, S_BASE_POP, S_B_POPT, S_B_POPA,
            S_B_POPP, S_FIN_POP: is_pop_st = 1'b1;
            default:             is_pop_st = 1'b0;
        endcase
    endfunction

    // Moore output decode; a blocked (over/underflowing) stack cycle drives no commands.
    function automatic ctl_t ctl_decode(input logic [4:0] st, input logic role,
                                        input logic vsel, input logic blocked);
        ctl_t c;
        c = '0;
        if (!blocked) begin
            case (st)
                S_LOAD:      begin c.we_nn = 1'b1; c.we_mm = 1'b1; end
                S_PUSH_ROOT: begin c.push = 1'b1; c.sn = 2'd2; c.sm = 2'd2; c.sc = 1'b1; end
                S_FETCH:     begin c.top = 1'b1; c.we_n = 1'b1; c.we_m = 1'b1; end
                S_EXP_POP:   begin c.pop = 1'b1; end
                S_EXP_PAR:   begin c.push = 1'b1; c.flag_in = {role, 1'b1}; end
                S_EXP_CHILD: begin c.push = 1'b1; c.sn = 2'd1; c.sc = 1'b1; end
                S_BASE_POP:  begin c.pop = 1'b1; end
                S_A_VAL:     begin c.push = 1'b1; c.sc = vsel; end
                S_A_CHILDB:  begin c.push = 1'b1; c.flag_in = 2'd2; c.sm = 2'd1; c.sc = 1'b1; end
                S_B_TMP:     begin c.push = 1'b1; c.sc = vsel; end
                S_B_POPT:    begin c.pop = 1'b1; c.we_2 = 1'b1; end
                S_B_POPA:    begin c.pop = 1'b1; c.we_1 = 1'b1; end
                S_B_POPP:    begin c.pop = 1'b1; c.we_n = 1'b1; c.we_m = 1'b1; end
                S_FIN_PUSH:  begin c.push = 1'b1; c.sc = vsel; end
                S_FIN_POP:   begin c.pop = 1'b1; c.we_1 = 1'b1; end
                S_DONE:      begin c.done = 1'b1; end
                default:     begin c = '0; end
            endcase
        end else begin
            c = '0;
        end
        c.busy = (st != S_IDLE) && (st != S_DONE);
        return c;
    endfunction

    // Next-state, stack-depth tracking and role/vsel/err bookkeeping.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        role_d  = role_q;
        vsel_d  = vsel_q;
        err_d   = err_q;
        fault_s = (is_push_st(state_q) && (depth_q == DEPTH_MAX)) ||
                  (is_pop_st(state_q)  && (depth_q == DEPTH_ZERO));
        if (fault_s) begin
            err_d   = 1'b1;
            state_d = S_DONE;
        end else begin
            if (is_push_st(state_q)) begin
                depth_d = depth_q + DEPTH_ONE;
            end else if (is_pop_st(state_q)) begin
                depth_d = depth_q - DEPTH_ONE;
            end else begin
                depth_d = depth_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (M > N) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            err_d   = 1'b0;
                            state_d = S_LOAD;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD:      state_d = S_PUSH_ROOT;
                S_PUSH_ROOT: state_d = S_FETCH;
                S_FETCH: begin
                    role_d  = Flag_Out[1];
                    state_d = S_EVAL;
                end
                // n/m were written at the end of FETCH, so Lend is valid here.
                S_EVAL:      state_d = Lend ? S_BASE_POP : S_EXP_POP;
                S_EXP_POP:   state_d = S_EXP_PAR;
                S_EXP_PAR:   state_d = S_EXP_CHILD;
                S_EXP_CHILD: state_d = S_FETCH;
                S_BASE_POP: begin
                    vsel_d  = 1'b1;
                    state_d = S_RES;
                end
                S_RES: begin
                    if (end_) begin
                        state_d = S_FIN_PUSH;
                    end else begin
                        state_d = role_q ? S_B_TMP : S_A_VAL;
                    end
                end
                S_A_VAL:    state_d = S_A_CHILDB;
                S_A_CHILDB: state_d = S_FETCH;
                // B resolved: park V, then unwind B value, A value and parent.
                S_B_TMP:    state_d = S_B_POPT;
                S_B_POPT:   state_d = S_B_POPA;
                S_B_POPA:   state_d = S_B_POPP;
                S_B_POPP: begin
                    role_d  = Flag_Out[1];
                    vsel_d  = 1'b0;
                    state_d = S_RES;
                end
                S_FIN_PUSH: state_d = S_FIN_POP;
                S_FIN_POP:  state_d = S_DONE;
                S_DONE:     state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // A stack command in the next state is suppressed if it would over/underflow.
    assign blocked_d_s = (is_push_st(state_d) && (depth_d == DEPTH_MAX)) ||
                         (is_pop_st(state_d)  && (depth_d == DEPTH_ZERO));

    // State, bookkeeping and registered output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            depth_q <= DEPTH_ZERO;
            role_q  <= 1'b0;
            vsel_q  <= 1'b0;
            err_q   <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            role_q  <= role_d;
            vsel_q  <= vsel_d;
            err_q   <= err_d;
            ctl_q   <= ctl_decode(state_d, role_d, vsel_d, blocked_d_s);
        end
    end

    assign Sn      = ctl_q.sn;
    assign Sm      = ctl_q.sm;
    assign Sc      = ctl_q.sc;
    assign Flag_In = ctl_q.flag_in;
    assign weN     = ctl_q.we_nn;
    assign weM     = ctl_q.we_mm;
    assign wen     = ctl_q.we_n;
    assign wem     = ctl_q.we_m;
    assign we1     = ctl_q.we_1;
    assign we2     = ctl_q.we_2;
    assign push    = ctl_q.push;
    assign pop     = ctl_q.pop;
    assign top     = ctl_q.top;
    assign busy    = ctl_q.busy;
    assign done    = ctl_q.done;
    assign err     = err_q;

`ifdef CNTRL_CYCLE_COUNT_EN
    logic [15:0] cycles_q, cycles_d;

    // Busy-cycle counter: cleared by a start taken in IDLE, saturating.
    always_comb begin
        if ((state_q == S_IDLE) && start) begin
            cycles_d = 16'h0000;
        end else if ((state_q != S_IDLE) && (state_q != S_DONE) && (cycles_q != 16'hFFFF)) begin
            cycles_d = cycles_q + 16'h0001;
        end else begin
            cycles_d = cycles_q;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= 16'h0000;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_comb_controller.sv
// Testbench for comb_controller: two controller instances (default depth and
// STACK_DEPTH=4) share one behavioural model of the combination datapath
// (N/M/n/m registers, comb1/comb2, frame stack); the idle controller drives
// all-zero controls, so the model takes the OR of both.
module tb_comb_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, sel;
    logic [3:0] N, M;
    logic       Lend, end_;
    logic [1:0] Flag_Out;

    logic [1:0] sn_a, sm_a, fi_a, sn_b, sm_b, fi_b;
    logic sc_a, wN_a, wM_a, wn_a, wm_a, w1_a, w2_a, push_a, pop_a, top_a, busy_a, done_a, err_a;
    logic sc_b, wN_b, wM_b, wn_b, wm_b, w1_b, w2_b, push_b, pop_b, top_b, busy_b, done_b, err_b;
`ifdef CNTRL_CYCLE_COUNT_EN
    logic [15:0] cyc_a, cyc_b;
`endif

    comb_controller dut_a (
        .clk(clk), .rst(rst), .start(start_a), .N(N), .M(M), .Lend(Lend), .end_(end_),
        .Flag_Out(Flag_Out), .Sn(sn_a), .Sm(sm_a), .Sc(sc_a), .Flag_In(fi_a),
        .weN(wN_a), .weM(wM_a), .wen(wn_a), .wem(wm_a), .we1(w1_a), .we2(w2_a),
        .push(push_a), .pop(pop_a), .top(top_a), .busy(busy_a), .done(done_a),
`ifdef CNTRL_CYCLE_COUNT_EN
        .cycles(cyc_a),
`endif
        .err(err_a)
    );

    comb_controller #(.STACK_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .N(N), .M(M), .Lend(Lend), .end_(end_),
        .Flag_Out(Flag_Out), .Sn(sn_b), .Sm(sm_b), .Sc(sc_b), .Flag_In(fi_b),
        .weN(wN_b), .weM(wM_b), .wen(wn_b), .wem(wm_b), .we1(w1_b), .we2(w2_b),
        .push(push_b), .pop(pop_b), .top(top_b), .busy(busy_b), .done(done_b),
`ifdef CNTRL_CYCLE_COUNT_EN
        .cycles(cyc_b),
`endif
        .err(err_b)
    );

    // ---------------- datapath model ----------------
    logic [1:0]  m_sn, m_sm, m_fi;
    logic        m_sc, m_wN, m_wM, m_wn, m_wm, m_w1, m_w2, m_push, m_pop, m_top;
    logic [22:0] stk [0:63];
    logic [5:0]  sp, cap_s;
    logic [3:0]  rN, rM, rn, rm, in_n, in_m;
    logic [12:0] c1, c2, in_v;
    logic [22:0] out_f;
    int push_cnt = 0, pop_cnt = 0, bad_push = 0, bad_pop = 0, bad_cap = 0;

    always_comb begin
        m_sn = sn_a | sn_b;  m_sm = sm_a | sm_b;  m_fi = fi_a | fi_b;  m_sc = sc_a | sc_b;
        m_wN = wN_a | wN_b;  m_wM = wM_a | wM_b;  m_wn = wn_a | wn_b;  m_wm = wm_a | wm_b;
        m_w1 = w1_a | w1_b;  m_w2 = w2_a | w2_b;  m_push = push_a | push_b;
        m_pop = pop_a | pop_b;  m_top = top_a | top_b;
        cap_s = sel ? 6'd4 : 6'd32;
        out_f = (sp > 6'd0) ? stk[sp - 6'd1] : 23'd0;
        in_n = (m_sn == 2'd0) ? rn : ((m_sn == 2'd1) ? rn - 4'd1 : rN);
        in_m = (m_sm == 2'd0) ? rm : ((m_sm == 2'd1) ? rm - 4'd1 : rM);
        in_v = m_sc ? 13'd1 : c1 + c2;
    end

    assign Lend     = (rm == 4'd0) || (rn == rm);
    assign end_     = (rn == rN) && (rm == rM);
    assign Flag_Out = out_f[22:21];

    always @(posedge clk) begin
        if (rst) begin
            sp <= 6'd0; rN <= 4'd0; rM <= 4'd0; rn <= 4'd0; rm <= 4'd0; c1 <= 13'd0; c2 <= 13'd0;
        end else begin
            if (m_push) begin
                push_cnt <= push_cnt + 1;
                if (sp >= cap_s) bad_push <= bad_push + 1;
                else begin
                    stk[sp] <= {m_fi, in_n, in_m, in_v};
                    sp <= sp + 6'd1;
                end
            end
            if (m_pop) begin
                pop_cnt <= pop_cnt + 1;
                if (sp == 6'd0) bad_pop <= bad_pop + 1;
                else sp <= sp - 6'd1;
            end
            if ((m_wn || m_wm || m_w1 || m_w2) && !(m_top || m_pop)) bad_cap <= bad_cap + 1;
            if (m_wN) rN <= N;
            if (m_wM) rM <= M;
            if (m_wn) rn <= out_f[20:17];
            if (m_wm) rm <= out_f[16:13];
            if (m_w1) c1 <= out_f[12:0];
            if (m_w2) c2 <= out_f[12:0];
        end
    end

    // ---------------- bench ----------------
    int n_checks = 0, n_fail = 0;

    task automatic run(input logic which, input logic [3:0] n, input logic [3:0] m,
                       output int cyc, output logic to);
        @(negedge clk);
        sel = which; N = n; M = m;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        cyc = 0; to = 1'b1;
        for (int k = 0; k < 40000; k++) begin
            @(negedge clk);
            cyc++;
            if (which ? done_b : done_a) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; N = 4'd0; M = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_a); end
        n_checks++;
        if ({sn_a, sm_a, sc_a, fi_a, wN_a, wM_a, wn_a, wm_a, w1_a, w2_a, push_a, pop_a, top_a} !== 16'd0) begin
            n_fail++; $display("FAIL reset_ctl: got %h want 0",
                {sn_a, sm_a, sc_a, fi_a, wN_a, wM_a, wn_a, wm_a, w1_a, w2_a, push_a, pop_a, top_a});
        end
        n_checks++; if ({busy_b, done_b, err_b} !== 3'd0) begin n_fail++; $display("FAIL reset_b: got %b want 000", {busy_b, done_b, err_b}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_base_m0();
        int cyc; logic to;
        run(1'b0, 4'd5, 4'd0, cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL base_timeout: no done"); end
        n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL base_latency: got %0d want 9", cyc); end
        n_checks++; if (c1 !== 13'd1) begin n_fail++; $display("FAIL base_out: got %0d want 1", c1); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL base_err: got %b want 0", err_a); end
        n_checks++; if (sp !== 6'd0) begin n_fail++; $display("FAIL base_depth: got %0d want 0", sp); end
    endtask

    task automatic test_c42();
        int cyc, p0, q0; logic to;
        p0 = push_cnt; q0 = pop_cnt;
        run(1'b0, 4'd4, 4'd2, cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL c42_timeout: no done"); end
        n_checks++; if (c1 !== 13'd6) begin n_fail++; $display("FAIL c42_out: got %0d want 6", c1); end
        n_checks++; if ((push_cnt - p0) != (pop_cnt - q0)) begin
            n_fail++; $display("FAIL c42_balance: pushes %0d pops %0d", push_cnt - p0, pop_cnt - q0); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL c42_err: got %b want 0", err_a); end
        @(negedge clk);
        n_checks++; if ({done_a, busy_a} !== 2'b00) begin n_fail++; $display("FAIL c42_pulse: got %b want 00", {done_a, busy_a}); end
    endtask

    task automatic test_large();
        int cyc; logic to;
        run(1'b0, 4'd12, 4'd6, cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL c126_timeout: no done"); end
        n_checks++; if (c1 !== 13'd924) begin n_fail++; $display("FAIL c126_out: got %0d want 924", c1); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL c126_err: got %b want 0", err_a); end
        run(1'b0, 4'd15, 4'd13, cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL c1513_timeout: no done"); end
        n_checks++; if (c1 !== 13'd105) begin n_fail++; $display("FAIL c1513_out: got %0d want 105", c1); end
        n_checks++; if ({bad_push, bad_pop, bad_cap} != 0) begin
            n_fail++; $display("FAIL stack_proto: ovf %0d unf %0d cap %0d want 0", bad_push, bad_pop, bad_cap); end
    endtask

    task automatic test_m_gt_n();
        int cyc, p0; logic to; logic [12:0] keep;
        keep = c1; p0 = push_cnt;
        run(1'b0, 4'd2, 4'd3, cyc, to);
        n_checks++; if (cyc != 1 || to) begin n_fail++; $display("FAIL mgtn_latency: got %0d want 1", cyc); end
        n_checks++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL mgtn_err: got %b want 1", err_a); end
        n_checks++; if (push_cnt != p0) begin n_fail++; $display("FAIL mgtn_push: got %0d pushes want 0", push_cnt - p0); end
        n_checks++; if (c1 !== keep) begin n_fail++; $display("FAIL mgtn_out: got %0d want %0d", c1, keep); end
        @(negedge clk);
        n_checks++; if ({err_a, done_a} !== 2'b10) begin n_fail++; $display("FAIL mgtn_sticky: got %b want 10", {err_a, done_a}); end
    endtask

    task automatic test_reset_midrun();
        int cyc; logic to;
        @(negedge clk); sel = 1'b0; N = 4'd6; M = 4'd3; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b want 1", busy_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL start_clears_err: got %b want 0", err_a); end
        N = 4'd2; M = 4'd3; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy_a, err_a, done_a} !== 3'b100) begin
            n_fail++; $display("FAIL busy_start_ignored: got %b want 100", {busy_a, err_a, done_a}); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_checks++; if ({busy_a, sp} !== 7'd0) begin n_fail++; $display("FAIL midrun_reset: busy %b depth %0d want 0", busy_a, sp); end
        run(1'b0, 4'd4, 4'd1, cyc, to);
        n_checks++; if (to || c1 !== 13'd4) begin n_fail++; $display("FAIL after_reset_out: got %0d want 4", c1); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL after_reset_err: got %b want 0", err_a); end
    endtask

    task automatic test_overflow();
        int cyc, b0; logic to;
        b0 = bad_push;
        run(1'b1, 4'd8, 4'd4, cyc, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL ovf_timeout: no done"); end
        n_checks++; if (err_b !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", err_b); end
        n_checks++; if (bad_push != b0) begin n_fail++; $display("FAIL ovf_push_full: got %0d want 0", bad_push - b0); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        run(1'b1, 4'd3, 4'd1, cyc, to);
        n_checks++; if (to || c1 !== 13'd3) begin n_fail++; $display("FAIL small_depth_out: got %0d want 3", c1); end
        n_checks++; if (err_b !== 1'b0 || bad_push != b0) begin
            n_fail++; $display("FAIL small_depth_err: err %b ovf %0d want 0", err_b, bad_push - b0); end
    endtask

    initial begin
        test_reset();
        test_base_m0();
        test_c42();
        test_large();
        test_m_gt_n();
        test_reset_midrun();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
